// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer: PC, imem addressing, 2-entry decode buffer
// Handles redirects, halt instruction and out-of-range/misaligned fetch faults.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] HALT_INSTR  = 32'hFC00_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT,
        S_FAULT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];
    logic        r_head;
    logic [1:0]  r_count;

    logic w_pop;
    logic w_space;
    logic w_in_range;
    logic w_fetch;
    logic w_tail;
    logic w_is_halt;
    logic w_aligned;
    logic w_flush;

    assign w_pop      = (r_count != 2'd0) && out_ready;
    assign w_space    = (r_count != 2'd2) || w_pop;
    assign w_in_range = (r_pc >> 2) < 32'(DEPTH_WORDS);
    assign w_fetch    = (r_state == S_RUN) && !redirect_valid && w_space && w_in_range;
    // Tail slot is head when empty or full; a full buffer only accepts a push alongside a pop.
    assign w_tail     = r_head ^ r_count[0];
    assign w_is_halt  = (imem_instr == HALT_INSTR);
    assign w_aligned  = (redirect_pc[1:0] == 2'b00);
    assign w_flush    = redirect_valid && ((r_state == S_RUN) || (r_state == S_HALT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_pc           <= RESET_PC;
            r_head         <= 1'b0;
            r_count        <= 2'd0;
            r_buf_pc[0]    <= 32'h0;
            r_buf_pc[1]    <= 32'h0;
            r_buf_instr[0] <= 32'h0;
            r_buf_instr[1] <= 32'h0;
        end else begin
            if (w_pop) begin
                r_head <= ~r_head;
            end
            if (w_fetch) begin
                r_buf_pc[w_tail]    <= r_pc;
                r_buf_instr[w_tail] <= imem_instr;
            end
            if (w_flush) begin
                r_count <= 2'd0;
            end else begin
                r_count <= r_count + {1'b0, w_fetch} - {1'b0, w_pop};
            end

            case (r_state)
                S_IDLE: begin
                    if (redirect_valid && w_aligned) begin
                        r_pc <= redirect_pc;
                    end
                    if (start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN, S_HALT: begin
                    if (redirect_valid) begin
                        if (w_aligned) begin
                            r_pc    <= redirect_pc;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_FAULT;
                        end
                    end else if ((r_state == S_RUN) && w_space) begin
                        if (!w_in_range) begin
                            r_state <= S_FAULT;
                        end else if (w_is_halt) begin
                            r_state <= S_HALT;
                        end else begin
                            r_pc <= r_pc + 32'd4;
                        end
                    end
                end
                default: begin
                    r_state <= S_FAULT;
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign out_valid = (r_count != 2'd0);
    assign out_pc    = r_buf_pc[r_head];
    assign out_instr = r_buf_instr[r_head];
    assign halted    = (r_state == S_HALT);
    assign fault     = (r_state == S_FAULT);

endmodule
